// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and status-flag bit positions.
// Used by the ALU op decode and by the result buffer.
package alu_pkg;

    localparam int OPW   = 3;
    localparam int FLAGW = 4;

    // Flags travel as {Z,N,C,V}, MSB first.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [OPW-1:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_XOR = 3'd4
    } alu_op_e;

    function automatic logic is_arith(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation from ALU operands, result and adder carry.
// Illegal op codes fall through with C=V=0.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    output logic [FLAGW-1:0] flags
);

    logic a_msb;
    logic b_msb;
    logic r_msb;

    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];
    assign r_msb = result[WIDTH-1];

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = r_msb;
        flags[FLAG_C] = is_arith(op) ? carry : 1'b0;
        case (op)
            OP_ADD:  flags[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB:  flags[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
            default: flags[FLAG_V] = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Queues ALU results with derived flags and op code in a DEPTH-entry FIFO
// between the ALU and the register-file writeback; counts retired operations.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [FLAGW-1:0] out_flags,
    output logic [OPW-1:0]   out_op,
    output logic [CNTW-1:0]  ops_retired
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [FLAGW-1:0] flags;
        logic [OPW-1:0]   op;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] ops_retired_q, ops_retired_d;

    logic [FLAGW-1:0] in_flags;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    entry_t           head;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (in_result),
        .carry  (in_carry),
        .flags  (in_flags)
    );

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ops_retired_d = ops_retired_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{result: in_result, flags: in_flags, op: in_op};
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (ops_retired_q != '1) begin
                ops_retired_d = ops_retired_q + 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    // NOTE: storage is reset too, so out_* read zero after reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ops_retired_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ops_retired_q <= ops_retired_d;
            mem_q         <= mem_d;
        end
    end

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign out_result  = head.result;
    assign out_flags   = head.flags;
    assign out_op      = head.op;
    assign ops_retired = ops_retired_q;

endmodule
